// File: rtl/ripple_adder_pkg.sv
// Bit-level helpers shared by the ripple adder and its full-adder cell.
package ripple_adder_pkg;

  localparam int MAX_WIDTH = 32;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Same-sign operands producing a result of the opposite sign.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/ripple_adder_full_adder.sv
// Purely combinational 1-bit full adder cell used as one ripple stage.
module full_adder
  import ripple_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = fa_sum(a, b, cin);
  assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder with a single registered output stage.
module ripple_adder
  import ripple_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  assign carry[0] = Cin;

  // Carry chain: stage i consumes carry[i] and produces carry[i+1].
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum;
      cout_d      = carry[WIDTH];
      ovf_d       = ovf_flag(A[WIDTH-1], B[WIDTH-1], sum[WIDTH-1]);
      out_valid_d = 1'b1;
    end
  end

  // Output register stage; reset wins over a simultaneous valid input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_adder.sv
// Directed and exhaustive checks of the 4-bit registered ripple adder.
module tb_ripple_adder;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       in_valid;
  logic [3:0] S;
  logic       Cout;
  logic       Ovf;
  logic       out_valid;

  int checks;
  int failures;

  ripple_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    A        = a;
    B        = b;
    Cin      = c;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] es, input logic ec,
                         input logic eo, input logic ev);
    chk({tag, "_S"},         {28'd0, S},   {28'd0, es});
    chk({tag, "_Cout"},      {31'd0, Cout}, {31'd0, ec});
    chk({tag, "_Ovf"},       {31'd0, Ovf},  {31'd0, eo});
    chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    A        = 4'd5;
    B        = 4'd4;
    Cin      = 1'b0;
    in_valid = 1'b1;

    // Reset held two cycles with a valid operand presented.
    apply(4'd5, 4'd4, 1'b0, 1'b1);
    apply(4'd5, 4'd4, 1'b0, 1'b1);
    chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    apply(4'd1, 4'd0, 1'b0, 1'b1);
    chk_out("sum_1_0_0", 4'd1, 1'b0, 1'b0, 1'b1);
    apply(4'd1, 4'd1, 1'b1, 1'b1);
    chk_out("sum_1_1_1", 4'd3, 1'b0, 1'b0, 1'b1);
    apply(4'd8, 4'd0, 1'b1, 1'b1);
    chk_out("sum_8_0_1", 4'd9, 1'b0, 1'b0, 1'b1);

    apply(4'd5, 4'd4, 1'b0, 1'b1);
    chk_out("ovf_5_4_0", 4'd9, 1'b0, 1'b1, 1'b1);
    apply(4'd5, 4'd4, 1'b1, 1'b1);
    chk_out("ovf_5_4_1", 4'd10, 1'b0, 1'b1, 1'b1);

    apply(4'd10, 4'd4, 1'b1, 1'b1);
    chk_out("sum_10_4_1", 4'd15, 1'b0, 1'b0, 1'b1);
    apply(4'd15, 4'd0, 1'b1, 1'b1);
    chk_out("wrap_15_0_1", 4'd0, 1'b1, 1'b0, 1'b1);
    apply(4'd2, 4'd10, 1'b0, 1'b1);
    chk_out("sum_2_10_0", 4'd12, 1'b0, 1'b0, 1'b1);

    apply(4'd3, 4'd0, 1'b1, 1'b1);
    chk_out("hold_load", 4'd4, 1'b0, 1'b0, 1'b1);
    apply(4'd10, 4'd4, 1'b0, 1'b0);
    chk_out("hold_idle", 4'd4, 1'b0, 1'b0, 1'b0);

    // Inputs changing between edges must not reach the outputs.
    in_valid = 1'b1;
    A        = 4'd15;
    B        = 4'd15;
    Cin      = 1'b1;
    #2;
    chk_out("between_edges", 4'd4, 1'b0, 1'b0, 1'b0);
    #2;

    // Mid-stream reset with a valid operand, then first result afterwards.
    rst = 1'b1;
    apply(4'd7, 4'd7, 1'b1, 1'b1);
    chk_out("reset_mid", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    apply(4'd7, 4'd7, 1'b1, 1'b1);
    chk_out("post_reset", 4'd15, 1'b0, 1'b1, 1'b1);

    // Exhaustive back-to-back sweep of all operand/carry combinations.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          int total;
          int sa;
          int sb;
          int ssum;
          logic eovf;
          total = a + b + c;
          sa    = (a >= 8) ? a - 16 : a;
          sb    = (b >= 8) ? b - 16 : b;
          ssum  = sa + sb + c;
          eovf  = (ssum > 7) || (ssum < -8);
          apply(4'(a), 4'(b), 1'(c), 1'b1);
          chk("exh_sum", {27'd0, Cout, S}, 32'(total));
          chk("exh_ovf", {31'd0, Ovf}, {31'd0, eovf});
          chk("exh_valid", {31'd0, out_valid}, 32'd1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ripple_adder.md
RIPPLE_ADDER -- requirements
Module: ripple_adder

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand and sum bit width (legal range 1..32).
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port A, input, WIDTH bits: unsigned operand A.
REQ-005 Port B, input, WIDTH bits: unsigned operand B.
REQ-006 Port Cin, input, 1 bit: carry-in.
REQ-007 Port in_valid, input, 1 bit: A/B/Cin are sampled this cycle.
REQ-008 Port S, output, WIDTH bits: registered sum.
REQ-009 Port Cout, output, 1 bit: registered carry-out of the MSB stage.
REQ-010 Port Ovf, output, 1 bit: registered two's-complement overflow flag.
REQ-011 Port out_valid, output, 1 bit: S/Cout/Ovf hold a result produced from a valid input.

Function
REQ-012 The adder core SHALL form {Cout,S} = A + B + Cin as WIDTH cascaded 1-bit full adders, with the carry of stage i feeding stage i+1.
REQ-013 Stage 0 carry-in SHALL be Cin; Cout SHALL be the carry-out of stage WIDTH-1. No lookahead or "+" operator in the core.
REQ-014 Full-adder equations: s = a^b^c; co = (a&b)|(a&c)|(b&c).
REQ-015 Ovf SHALL equal (A[MSB]==B[MSB]) && (S[MSB]!=A[MSB]), computed from the same operands.
REQ-016 Latency SHALL be exactly 1 cycle: when in_valid=1 at edge N, S/Cout/Ovf SHALL show the result after edge N and out_valid SHALL be 1.
REQ-017 When in_valid=0 at an edge, S/Cout/Ovf SHALL hold their previous values and out_valid SHALL be 0 for that cycle.
REQ-018 Back-to-back in_valid cycles SHALL produce one result per cycle; there is no backpressure.
REQ-019 Wrap-around: a sum of 2^WIDTH or more SHALL keep the low WIDTH bits in S and set Cout=1 (e.g. 15+0+1 gives S=0, Cout=1).
REQ-020 Input changes between edges SHALL NOT affect the outputs until the next sampling edge.

Reset
REQ-021 When rst=1 at a rising edge: S=0, Cout=0, Ovf=0, out_valid=0.
REQ-022 rst SHALL override in_valid in the same cycle; an operand presented during reset is discarded.
REQ-023 After rst deasserts, the first valid input SHALL produce its result with the normal 1-cycle latency.

Structure
REQ-024 A sub-module full_adder (ports a, b, cin, s, cout) SHALL be instantiated WIDTH times in a generate loop.
REQ-025 No shared package is required; WIDTH is the only configuration item and stays a module parameter.
REQ-026 The output register stage SHALL be a single clocked process in ripple_adder; full_adder SHALL be purely combinational.

Verification
REQ-027 Reset: rst=1 for 2 cycles with A=5, B=4, in_valid=1 -> S=0, Cout=0, Ovf=0, out_valid=0.
REQ-028 Basic sums, in sequence with in_valid=1 (WIDTH=4), one cycle after each input:
- A=1,B=0,Cin=0 -> S=1
- A=1,B=1,Cin=1 -> S=3
- A=8,B=0,Cin=1 -> S=9, Cout=0
REQ-029 Signed overflow: A=5, B=4, Cin=0 -> S=9, Cout=0, Ovf=1; then Cin=1 -> S=10, Ovf=1.
REQ-030 Carry-out: A=10, B=4, Cin=1 -> S=15, Cout=0; then A=15, B=0, Cin=1 -> S=0, Cout=1, Ovf=0; then A=2, B=10, Cin=0 -> S=12.
REQ-031 Hold: result S=4 from A=3, B=0, Cin=1; then in_valid=0 with A=10, B=4 -> S stays 4 and out_valid=0.
REQ-032 Exhaustive check: all 512 combinations of A, B, Cin at WIDTH=4, back-to-back -> each {Cout,S} equals A+B+Cin one cycle later.
